// File: rtl/cgra_pkg.sv
// Shared constants for the CGRA-to-OBI bridge: default in-flight limit and counter sizing.
package cgra_pkg;

    localparam int MAX_OUTST_DEF = 2;

    // Counter must hold the value MAX_OUTST itself, hence +1.
    function automatic int outst_cnt_w(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

endpackage

// File: rtl/cgra_obi_port.sv
// One bridge lane: admission control, outstanding counter, held-request tracking, spurious-rvalid flag.
// Zero-latency request/grant gating; blocks new requests at MAX_OUTST in flight or while quiescing.
module cgra_obi_port
    import cgra_pkg::*;
#(
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic quiesce_i,
    input  logic tcdm_req_i,
    input  logic obi_gnt_i,
    input  logic obi_rvalid_i,
    output logic obi_req_o,
    output logic tcdm_gnt_o,
    output logic busy_o,
    output logic outst_err_o
);

    localparam int CW = outst_cnt_w(MAX_OUTST);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          err_q, err_d;
    logic          allow;
    logic          fire;

    // A request already on the bus without grant must stay up, whatever quiesce_i does.
    assign allow      = pend_q | (!quiesce_i && (cnt_q < CNT_MAX));
    assign obi_req_o  = tcdm_req_i & allow;
    assign tcdm_gnt_o = obi_gnt_i & allow;
    assign fire       = obi_req_o & obi_gnt_i;

    always_comb begin
        cnt_d  = cnt_q;
        err_d  = err_q;
        pend_d = obi_req_o & ~obi_gnt_i;
        if (fire && !obi_rvalid_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!fire && obi_rvalid_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (obi_rvalid_i && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign busy_o      = pend_q | (cnt_q != '0);
    assign outst_err_o = err_q;

endmodule

// File: rtl/cgra_obi_master_bridge.sv
// N-port CGRA TCDM to OBI master bridge with quiesce/drain, plus sticky maskable event interrupt.
// Requests and responses pass combinationally; int_o is registered one cycle after the event.
module cgra_obi_master_bridge
    import cgra_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = MAX_OUTST_DEF,
    parameter int N_EVT     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_PORTS-1:0]          tcdm_req_i,
    input  logic [N_PORTS*ADDR_W-1:0]   tcdm_add_i,
    input  logic [N_PORTS-1:0]          tcdm_wen_i,
    input  logic [N_PORTS*DATA_W/8-1:0] tcdm_be_i,
    input  logic [N_PORTS*DATA_W-1:0]   tcdm_wdata_i,
    output logic [N_PORTS-1:0]          tcdm_gnt_o,
    output logic [N_PORTS*DATA_W-1:0]   tcdm_rdata_o,
    output logic [N_PORTS-1:0]          tcdm_rvalid_o,
    output logic [N_PORTS-1:0]          obi_req_o,
    output logic [N_PORTS*ADDR_W-1:0]   obi_addr_o,
    output logic [N_PORTS-1:0]          obi_we_o,
    output logic [N_PORTS*DATA_W/8-1:0] obi_be_o,
    output logic [N_PORTS*DATA_W-1:0]   obi_wdata_o,
    input  logic [N_PORTS-1:0]          obi_gnt_i,
    input  logic [N_PORTS-1:0]          obi_rvalid_i,
    input  logic [N_PORTS*DATA_W-1:0]   obi_rdata_i,
    input  logic                        quiesce_i,
    output logic                        idle_o,
    input  logic [N_EVT-1:0]            evt_i,
    input  logic [N_EVT-1:0]            evt_mask_i,
    input  logic [N_EVT-1:0]            evt_clr_i,
    output logic [N_EVT-1:0]            evt_pending_o,
    output logic                        int_o,
    output logic [N_PORTS-1:0]          outst_err_o
);

    logic [N_PORTS-1:0] busy;

    assign obi_addr_o    = tcdm_add_i;
    assign obi_we_o      = ~tcdm_wen_i;
    assign obi_be_o      = tcdm_be_i;
    assign obi_wdata_o   = tcdm_wdata_i;
    assign tcdm_rvalid_o = obi_rvalid_i;
    assign tcdm_rdata_o  = obi_rdata_i;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        cgra_obi_port #(
            .MAX_OUTST(MAX_OUTST)
        ) u_port (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .quiesce_i   (quiesce_i),
            .tcdm_req_i  (tcdm_req_i[p]),
            .obi_gnt_i   (obi_gnt_i[p]),
            .obi_rvalid_i(obi_rvalid_i[p]),
            .obi_req_o   (obi_req_o[p]),
            .tcdm_gnt_o  (tcdm_gnt_o[p]),
            .busy_o      (busy[p]),
            .outst_err_o (outst_err_o[p])
        );
    end

    // busy is built only from flops, so idle_o cannot glitch on request-side inputs.
    assign idle_o = quiesce_i & ~(|busy);

    logic [N_EVT-1:0] evt_pend_q, evt_pend_d;
    logic             int_q;

    // Set dominates clear so an event coinciding with its acknowledge is not lost.
    assign evt_pend_d = (evt_pend_q & ~evt_clr_i) | evt_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_pend_q <= '0;
            int_q      <= 1'b0;
        end else begin
            evt_pend_q <= evt_pend_d;
            int_q      <= |(evt_pend_d & evt_mask_i);
        end
    end

    assign evt_pending_o = evt_pend_q;
    assign int_o         = int_q;

endmodule

// File: tb/tb_cgra_obi_master_bridge.sv
// Directed bench for cgra_obi_master_bridge: lane traffic, limits, quiesce/drain, error flag, events.
module tb_cgra_obi_master_bridge;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NE = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NP-1:0]         tcdm_req;
    logic [NP*AW-1:0]      tcdm_add;
    logic [NP-1:0]         tcdm_wen;
    logic [NP*DW/8-1:0]    tcdm_be;
    logic [NP*DW-1:0]      tcdm_wdata;
    logic [NP-1:0]         tcdm_gnt;
    logic [NP*DW-1:0]      tcdm_rdata;
    logic [NP-1:0]         tcdm_rvalid;
    logic [NP-1:0]         obi_req;
    logic [NP*AW-1:0]      obi_addr;
    logic [NP-1:0]         obi_we;
    logic [NP*DW/8-1:0]    obi_be;
    logic [NP*DW-1:0]      obi_wdata;
    logic [NP-1:0]         obi_gnt;
    logic [NP-1:0]         obi_rvalid;
    logic [NP*DW-1:0]      obi_rdata;
    logic                  quiesce;
    logic                  idle;
    logic [NE-1:0]         evt, evt_mask, evt_clr, evt_pending;
    logic                  int_w;
    logic [NP-1:0]         outst_err;

    int total = 0;
    int bad   = 0;

    cgra_obi_master_bridge #(
        .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(2), .N_EVT(NE)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .tcdm_req_i(tcdm_req), .tcdm_add_i(tcdm_add), .tcdm_wen_i(tcdm_wen),
        .tcdm_be_i(tcdm_be), .tcdm_wdata_i(tcdm_wdata),
        .tcdm_gnt_o(tcdm_gnt), .tcdm_rdata_o(tcdm_rdata), .tcdm_rvalid_o(tcdm_rvalid),
        .obi_req_o(obi_req), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
        .obi_be_o(obi_be), .obi_wdata_o(obi_wdata),
        .obi_gnt_i(obi_gnt), .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata),
        .quiesce_i(quiesce), .idle_o(idle),
        .evt_i(evt), .evt_mask_i(evt_mask), .evt_clr_i(evt_clr),
        .evt_pending_o(evt_pending), .int_o(int_w), .outst_err_o(outst_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        tcdm_req   = '0;
        tcdm_add   = '0;
        tcdm_wen   = '1;
        tcdm_be    = '0;
        tcdm_wdata = '0;
        obi_gnt    = '0;
        obi_rvalid = '0;
        obi_rdata  = '0;
        quiesce    = 1'b0;
        evt        = '0;
        evt_mask   = '0;
        evt_clr    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_obi_req", 64'(obi_req), 64'h0);
        chk("rst_tcdm_gnt", 64'(tcdm_gnt), 64'h0);
        chk("rst_rvalid", 64'(tcdm_rvalid), 64'h0);
        chk("rst_int", 64'(int_w), 64'h0);
        chk("rst_err", 64'(outst_err), 64'h0);
        chk("rst_pending", 64'(evt_pending), 64'h0);
        chk("rst_idle_noq", 64'(idle), 64'h0);
        quiesce = 1'b1;
        settle();
        chk("rst_idle_q", 64'(idle), 64'h1);
        quiesce = 1'b0;

        // Write on port 0, granted immediately, response two cycles later.
        tcdm_req[0]        = 1'b1;
        tcdm_wen[0]        = 1'b0;
        tcdm_add[31:0]     = 32'h0000_1000;
        tcdm_wdata[31:0]   = 32'hCAFE_F00D;
        tcdm_be[3:0]       = 4'hF;
        obi_gnt[0]         = 1'b1;
        settle();
        chk("wr_obi_req", 64'(obi_req), 64'h1);
        chk("wr_we", 64'(obi_we[0]), 64'h1);
        chk("wr_addr", 64'(obi_addr[31:0]), 64'h1000);
        chk("wr_wdata", 64'(obi_wdata[31:0]), 64'hCAFEF00D);
        chk("wr_be", 64'(obi_be[3:0]), 64'hF);
        chk("wr_gnt", 64'(tcdm_gnt), 64'h1);
        tick();
        idle_inputs();
        quiesce = 1'b1;
        settle();
        chk("wr_cnt1_notidle", 64'(idle), 64'h0);
        tick();
        obi_rvalid[0]     = 1'b1;
        obi_rdata[31:0]   = 32'h1234_5678;
        settle();
        chk("wr_rvalid", 64'(tcdm_rvalid), 64'h1);
        chk("wr_rdata", 64'(tcdm_rdata[31:0]), 64'h12345678);
        tick();
        obi_rvalid = '0;
        settle();
        chk("wr_rvalid_once", 64'(tcdm_rvalid), 64'h0);
        chk("wr_cnt0_idle", 64'(idle), 64'h1);
        chk("wr_no_err", 64'(outst_err), 64'h0);
        quiesce = 1'b0;

        // Three back-to-back reads on port 1 with no response: the third must wait.
        tcdm_req[1] = 1'b1;
        obi_gnt[1]  = 1'b1;
        tcdm_add[63:32] = 32'h0000_2000;
        settle();
        chk("rd1_req", 64'(obi_req), 64'h2);
        chk("rd1_we", 64'(obi_we[1]), 64'h0);
        tick();
        settle();
        chk("rd2_req", 64'(obi_req), 64'h2);
        tick();
        settle();
        chk("rd3_blocked_req", 64'(obi_req), 64'h0);
        chk("rd3_blocked_gnt", 64'(tcdm_gnt), 64'h0);
        obi_rvalid[1] = 1'b1;
        settle();
        chk("rd3_blocked_with_rvalid", 64'(obi_req), 64'h0);
        tick();
        obi_rvalid = '0;
        settle();
        chk("rd3_req_after_rvalid", 64'(obi_req), 64'h2);
        chk("rd3_gnt_after_rvalid", 64'(tcdm_gnt), 64'h2);
        tick();
        tcdm_req   = '0;
        obi_gnt    = '0;
        obi_rvalid[1] = 1'b1;
        tick();
        tick();
        obi_rvalid = '0;
        quiesce    = 1'b1;
        settle();
        chk("rd_drained_idle", 64'(idle), 64'h1);
        quiesce = 1'b0;

        // Port 2 request stalled by the bus while quiesce rises: it must stay up and stable.
        tcdm_req[2]      = 1'b1;
        tcdm_wen[2]      = 1'b1;
        tcdm_add[95:64]  = 32'hABCD_0040;
        settle();
        chk("q_c0_req", 64'(obi_req), 64'h4);
        chk("q_c0_gnt", 64'(tcdm_gnt), 64'h0);
        tick();
        quiesce = 1'b1;
        settle();
        chk("q_c1_req_held", 64'(obi_req), 64'h4);
        chk("q_c1_addr", 64'(obi_addr[95:64]), 64'hABCD0040);
        chk("q_c1_notidle", 64'(idle), 64'h0);
        tick();
        settle();
        chk("q_c2_req_held", 64'(obi_req), 64'h4);
        tick();
        obi_gnt[2] = 1'b1;
        settle();
        chk("q_c3_gnt", 64'(tcdm_gnt[2]), 64'h1);
        tick();
        tcdm_req    = '0;
        obi_gnt     = '0;
        tcdm_req[3] = 1'b1;
        settle();
        chk("q_new_blocked", 64'(obi_req), 64'h0);
        chk("q_inflight_notidle", 64'(idle), 64'h0);
        tcdm_req      = '0;
        tick();
        obi_rvalid[2] = 1'b1;
        settle();
        chk("q_rvalid_cycle_notidle", 64'(idle), 64'h0);
        tick();
        obi_rvalid = '0;
        settle();
        chk("q_idle_after_rvalid", 64'(idle), 64'h1);
        quiesce = 1'b0;

        // Port 3: grant and rvalid in the same cycle at cnt=1 leaves cnt at 1.
        tcdm_req[3] = 1'b1;
        obi_gnt[3]  = 1'b1;
        tick();
        obi_rvalid[3] = 1'b1;
        settle();
        chk("same_gnt_rv", 64'(tcdm_gnt), 64'h8);
        tick();
        obi_rvalid = '0;
        settle();
        chk("same_cnt1_allows", 64'(obi_req), 64'h8);
        tick();
        settle();
        chk("same_cnt2_blocks", 64'(obi_req), 64'h0);
        tcdm_req      = '0;
        obi_gnt       = '0;
        obi_rvalid[3] = 1'b1;
        tick();
        tick();
        obi_rvalid = '0;
        quiesce    = 1'b1;
        settle();
        chk("same_drained_idle", 64'(idle), 64'h1);
        chk("same_no_err", 64'(outst_err), 64'h0);
        quiesce = 1'b0;

        // Spurious rvalid on port 0 sets a sticky error.
        obi_rvalid[0] = 1'b1;
        tick();
        obi_rvalid = '0;
        settle();
        chk("err_set", 64'(outst_err), 64'h1);
        tick();
        tick();
        quiesce = 1'b1;
        settle();
        chk("err_sticky", 64'(outst_err), 64'h1);
        chk("err_cnt_stays0", 64'(idle), 64'h1);
        quiesce = 1'b0;

        // Events: masked event still latches, interrupt follows the mask one cycle later.
        evt = 4'b0010;
        tick();
        evt = '0;
        settle();
        chk("evt_pend_masked", 64'(evt_pending), 64'h2);
        chk("evt_int_masked", 64'(int_w), 64'h0);
        evt_mask = 4'b0010;
        settle();
        chk("evt_int_registered", 64'(int_w), 64'h0);
        tick();
        chk("evt_int_unmasked", 64'(int_w), 64'h1);
        evt     = 4'b0010;
        evt_clr = 4'b0010;
        tick();
        evt     = '0;
        evt_clr = '0;
        settle();
        chk("evt_set_wins", 64'(evt_pending), 64'h2);
        chk("evt_set_wins_int", 64'(int_w), 64'h1);
        evt_clr = 4'b0010;
        tick();
        evt_clr = '0;
        settle();
        chk("evt_cleared", 64'(evt_pending), 64'h0);
        chk("evt_int_cleared", 64'(int_w), 64'h0);
        evt_mask = 4'b0100;
        evt      = 4'b0100;
        settle();
        chk("evt_int_not_comb", 64'(int_w), 64'h0);
        tick();
        evt = '0;
        settle();
        chk("evt_int_next_cycle", 64'(int_w), 64'h1);
        chk("evt_pend_bit2", 64'(evt_pending), 64'h4);

        // Reset clears the sticky error and event state.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("rst2_err", 64'(outst_err), 64'h0);
        chk("rst2_pending", 64'(evt_pending), 64'h0);
        chk("rst2_int", 64'(int_w), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
